// File: rtl/execute_stage_if.sv
// ID/EX to EX/MEM bundle for the execute stage: hazard controls, ID/EX operands
// and control inputs, and the registered EX/MEM outputs.
interface execute_stage_if;
  logic        stall;
  logic        flush;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [31:0] sign_extended;
  logic [10:0] jump_dest_addr;
  logic [4:0]  reg_dest_r_type;
  logic [4:0]  reg_dest_l_type;
  logic        RegDst;
  logic        ALUSrc;
  logic        MemToReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic [1:0]  ALUOp;

  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        zero;
  logic [10:0] branch_dest_addr;
  logic [4:0]  write_reg;
  logic        MemToReg_out;
  logic        RegWrite_out;
  logic        MemRead_out;
  logic        MemWrite_out;
  logic        Branch_out;
  logic        pc_src;

  modport master (
    output stall, flush, data_a, data_b, sign_extended, jump_dest_addr,
           reg_dest_r_type, reg_dest_l_type, RegDst, ALUSrc, MemToReg,
           RegWrite, MemRead, MemWrite, Branch, ALUOp,
    input  alu_result, store_data, zero, branch_dest_addr, write_reg,
           MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out,
           Branch_out, pc_src
  );

  modport slave (
    input  stall, flush, data_a, data_b, sign_extended, jump_dest_addr,
           reg_dest_r_type, reg_dest_l_type, RegDst, ALUSrc, MemToReg,
           RegWrite, MemRead, MemWrite, Branch, ALUOp,
    output alu_result, store_data, zero, branch_dest_addr, write_reg,
           MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out,
           Branch_out, pc_src
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand/destination select, ALU control decode, ALU, zero
// detect, and the EX/MEM pipeline register with stall and flush.
module execute_stage (
  input  logic            clock,
  input  logic            reset,
  execute_stage_if.slave  bus
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT
  } alu_ctrl_e;

  function automatic alu_ctrl_e alu_decode(input logic [1:0] op, input logic [5:0] funct);
    alu_ctrl_e ctrl;
    ctrl = ALU_ADD;
    case (op)
      2'b00: ctrl = ALU_ADD;
      2'b01: ctrl = ALU_SUB;
      2'b11: ctrl = ALU_OR;
      default: begin
        case (funct)
          6'b100010: ctrl = ALU_SUB;
          6'b100100: ctrl = ALU_AND;
          6'b100101: ctrl = ALU_OR;
          6'b100110: ctrl = ALU_XOR;
          6'b100111: ctrl = ALU_NOR;
          6'b101010: ctrl = ALU_SLT;
          default:   ctrl = ALU_ADD;
        endcase
      end
    endcase
    return ctrl;
  endfunction

  // Arithmetic wraps modulo 2^32; slt is a signed compare
  function automatic logic [31:0] alu_exec(input alu_ctrl_e ctrl,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic [31:0] res;
    res = '0;
    case (ctrl)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_NOR: res = ~(a | b);
      ALU_SLT: res = (a < b) ? 32'd1 : 32'd0;
      default: res = a + b;
    endcase
    return res;
  endfunction

  logic signed [31:0] w_op_a;
  logic signed [31:0] w_op_b;
  logic [4:0]         w_dest;
  alu_ctrl_e          w_alu_ctrl;
  logic [31:0]        w_alu_result;
  logic               w_zero;

  always_comb begin
    w_op_a       = bus.data_a;
    w_op_b       = bus.ALUSrc ? bus.sign_extended : bus.data_b;
    w_dest       = bus.RegDst ? bus.reg_dest_r_type : bus.reg_dest_l_type;
    w_alu_ctrl   = alu_decode(bus.ALUOp, bus.sign_extended[5:0]);
    w_alu_result = alu_exec(w_alu_ctrl, w_op_a, w_op_b);
    w_zero       = (w_alu_result == 32'd0);
  end

  // EX/MEM register boundary
  logic [31:0] r_alu_result_p1;
  logic [31:0] r_store_data_p1;
  logic        r_zero_p1;
  logic [10:0] r_branch_dest_p1;
  logic [4:0]  r_write_reg_p1;
  logic        r_mem_to_reg_p1;
  logic        r_reg_write_p1;
  logic        r_mem_read_p1;
  logic        r_mem_write_p1;
  logic        r_branch_p1;
  logic        r_pc_src_p1;

  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      r_alu_result_p1  <= '0;
      r_store_data_p1  <= '0;
      r_zero_p1        <= 1'b0;
      r_branch_dest_p1 <= '0;
      r_write_reg_p1   <= '0;
      r_mem_to_reg_p1  <= 1'b0;
      r_reg_write_p1   <= 1'b0;
      r_mem_read_p1    <= 1'b0;
      r_mem_write_p1   <= 1'b0;
      r_branch_p1      <= 1'b0;
      r_pc_src_p1      <= 1'b0;
    end else if (!bus.stall) begin
      r_alu_result_p1  <= w_alu_result;
      r_store_data_p1  <= bus.data_b;
      r_zero_p1        <= w_zero;
      r_branch_dest_p1 <= bus.jump_dest_addr;
      r_write_reg_p1   <= w_dest;
      r_mem_to_reg_p1  <= bus.MemToReg;
      r_reg_write_p1   <= bus.RegWrite;
      r_mem_read_p1    <= bus.MemRead;
      r_mem_write_p1   <= bus.MemWrite;
      r_branch_p1      <= bus.Branch;
      r_pc_src_p1      <= bus.Branch & w_zero;
    end
  end

  assign bus.alu_result       = r_alu_result_p1;
  assign bus.store_data       = r_store_data_p1;
  assign bus.zero             = r_zero_p1;
  assign bus.branch_dest_addr = r_branch_dest_p1;
  assign bus.write_reg        = r_write_reg_p1;
  assign bus.MemToReg_out     = r_mem_to_reg_p1;
  assign bus.RegWrite_out     = r_reg_write_p1;
  assign bus.MemRead_out      = r_mem_read_p1;
  assign bus.MemWrite_out     = r_mem_write_p1;
  assign bus.Branch_out       = r_branch_p1;
  assign bus.pc_src           = r_pc_src_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: each driven cycle pushes the expected
// EX/MEM contents, popped and compared one edge later.
module tb_execute_stage;

  logic clock;
  logic reset;
  execute_stage_if u_if ();

  execute_stage u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [10:0] bda;
    logic [4:0]  wr;
    logic [6:0]  ctl; // {zero, pc_src, MemToReg, RegWrite, MemRead, MemWrite, Branch}
  } exp_t;

  exp_t q_exp[$];
  exp_t m_reg;
  int   n_chk;
  int   n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one cycle of inputs, advance the reference register, then compare
  task automatic step(input logic rst, input logic stl, input logic fls,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                      input logic [10:0] jd, input logic [4:0] rd, input logic [4:0] rt,
                      input logic regdst, input logic alusrc, input logic [1:0] aluop,
                      input logic m2r, input logic rw, input logic mr, input logic mw,
                      input logic br, input logic [31:0] exp_alu, input string tag);
    exp_t e;
    logic z;
    @(negedge clock);
    reset                  = rst;
    u_if.stall             = stl;
    u_if.flush             = fls;
    u_if.data_a            = a;
    u_if.data_b            = b;
    u_if.sign_extended     = se;
    u_if.jump_dest_addr    = jd;
    u_if.reg_dest_r_type   = rd;
    u_if.reg_dest_l_type   = rt;
    u_if.RegDst            = regdst;
    u_if.ALUSrc            = alusrc;
    u_if.ALUOp             = aluop;
    u_if.MemToReg          = m2r;
    u_if.RegWrite          = rw;
    u_if.MemRead           = mr;
    u_if.MemWrite          = mw;
    u_if.Branch            = br;
    z = (exp_alu == 32'd0);
    if (rst || fls) m_reg = '0;
    else if (!stl)  m_reg = '{alu: exp_alu, sd: b, bda: jd, wr: (regdst ? rd : rt),
                              ctl: {z, br & z, m2r, rw, mr, mw, br}};
    q_exp.push_back(m_reg);
    @(posedge clock);
    #1;
    e = q_exp.pop_front();
    check({tag, ".alu"}, u_if.alu_result, e.alu);
    check({tag, ".sd"},  u_if.store_data, e.sd);
    check({tag, ".bda"}, {21'd0, u_if.branch_dest_addr}, {21'd0, e.bda});
    check({tag, ".wr"},  {27'd0, u_if.write_reg}, {27'd0, e.wr});
    check({tag, ".ctl"}, {25'd0, u_if.zero, u_if.pc_src, u_if.MemToReg_out, u_if.RegWrite_out,
                          u_if.MemRead_out, u_if.MemWrite_out, u_if.Branch_out},
          {25'd0, e.ctl});
  endtask

  logic [5:0]  funct_tbl [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [31:0] rtype_exp [7] = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd2, 32'hFFFFFFF8, 32'd0};

  initial begin
    n_chk  = 0;
    n_pass = 0;
    m_reg  = '0;

    // Reset with arbitrary non-zero inputs
    for (int i = 0; i < 2; i++)
      step(1, 0, 0, 32'h123, 32'h456, 32'h0, 11'h7FF, 5'd31, 5'd30, 1, 0, 2'b01,
           1, 1, 1, 1, 1, 32'hFFFFFFFF, "reset");

    // R-type sweep: 7 op 5, rd = 3
    for (int i = 0; i < 7; i++)
      step(0, 0, 0, 32'd7, 32'd5, {26'd0, funct_tbl[i]}, 11'd0, 5'd3, 5'd8, 1, 0, 2'b10,
           0, 1, 0, 0, 0, rtype_exp[i], $sformatf("rtype%0d", i));
    step(0, 0, 0, 32'hFFFFFFFF, 32'd1, 32'h2A, 11'd0, 5'd3, 5'd8, 1, 0, 2'b10,
         0, 1, 0, 0, 0, 32'd1, "slt_neg");
    step(0, 0, 0, 32'd7, 32'd5, 32'h3F, 11'd0, 5'd4, 5'd8, 1, 0, 2'b10,
         0, 1, 0, 0, 0, 32'd12, "funct_dflt");
    step(0, 0, 0, 32'hF0, 32'hAAAA, 32'h0F, 11'd0, 5'd4, 5'd6, 0, 1, 2'b11,
         0, 1, 0, 0, 0, 32'hFF, "ori");

    // Load and store
    step(0, 0, 0, 32'd100, 32'd0, 32'hFFFFFFFC, 11'd0, 5'd2, 5'd9, 0, 1, 2'b00,
         1, 1, 1, 0, 0, 32'd96, "load");
    step(0, 0, 0, 32'd100, 32'hDEADBEEF, 32'd4, 11'd0, 5'd2, 5'd9, 0, 1, 2'b00,
         0, 0, 0, 1, 0, 32'd104, "store");

    // Branch taken / not taken
    step(0, 0, 0, 32'h55, 32'h55, 32'h4, 11'h123, 5'd0, 5'd0, 0, 0, 2'b01,
         0, 0, 0, 0, 1, 32'd0, "beq_t");
    step(0, 0, 0, 32'h55, 32'h56, 32'h4, 11'h123, 5'd0, 5'd0, 0, 0, 2'b01,
         0, 0, 0, 0, 1, 32'hFFFFFFFF, "beq_nt");

    // Stall holds for 3 cycles while inputs change
    step(0, 0, 0, 32'd1, 32'd2, 32'h20, 11'h11, 5'd5, 5'd6, 1, 0, 2'b10,
         0, 1, 0, 0, 0, 32'd3, "pre_stall");
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 32'd50 + i, 32'd60 + i, 32'h22, 11'h2A, 5'd7, 5'd8, 0, 0, 2'b01,
           1, 0, 1, 1, 1, 32'd0, $sformatf("stall%0d", i));
    step(0, 1, 1, 32'd9, 32'd9, 32'h0, 11'h55, 5'd7, 5'd8, 1, 0, 2'b00,
         1, 1, 1, 1, 1, 32'd18, "stall_flush");
    step(0, 0, 0, 32'd10, 32'd20, 32'h20, 11'h33, 5'd12, 5'd13, 1, 0, 2'b10,
         0, 1, 0, 0, 0, 32'd30, "release");
    step(0, 0, 1, 32'd10, 32'd20, 32'h20, 11'h33, 5'd12, 5'd13, 1, 0, 2'b10,
         0, 1, 0, 0, 0, 32'd30, "flush");
    step(0, 0, 0, 32'd3, 32'd3, 32'h0, 11'h44, 5'd1, 5'd2, 0, 0, 2'b01,
         0, 0, 0, 0, 1, 32'd0, "post_flush");
    step(1, 1, 0, 32'd3, 32'd4, 32'h0, 11'h44, 5'd1, 5'd2, 0, 0, 2'b00,
         0, 1, 0, 0, 1, 32'd7, "reset_stall");

    // Wrap-around
    step(0, 0, 0, 32'h7FFFFFFF, 32'd1, 32'h20, 11'd0, 5'd14, 5'd15, 1, 0, 2'b10,
         0, 1, 0, 0, 0, 32'h80000000, "wrap_pos");
    step(0, 0, 0, 32'hFFFFFFFF, 32'd1, 32'h20, 11'd0, 5'd14, 5'd15, 1, 0, 2'b10,
         0, 1, 0, 0, 0, 32'd0, "wrap_zero");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
